// File: rtl/multirate_mac_pipe_if.sv
// multirate_mac_pipe_if: valid/ready bundle for the MAC pipe.
// Tap beats in, rounded/saturated run sums out.
interface multirate_mac_pipe_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [din0_WIDTH-1:0] din0;
  logic        [din1_WIDTH-1:0] din1;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         dout_sat;

  modport slave (
    input  in_valid, din0, din1, in_last, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );

  modport master (
    output in_valid, din0, din1, in_last, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );
endinterface

// File: rtl/multirate_mac_pipe.sv
// multirate_mac_pipe: pipelined multiply-accumulate over tap runs.
// Rounds half-up, saturates, holds output under backpressure.
module multirate_mac_pipe #(
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 15,
  parameter bit DIN1_SIGNED = 1'b0,
  parameter int NUM_STAGE   = 2,
  parameter int GUARD_BITS  = 4,
  parameter int SHIFT       = 15,
  parameter int dout_WIDTH  = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  multirate_mac_pipe_if.slave bus
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam int A  = P + GUARD_BITS;
  localparam int AW = A + 1;
  localparam int W1 = din1_WIDTH + 1;

  localparam logic signed [AW-1:0] RND =
    (AW'(1) << SHIFT) >> 1;
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

  logic                         en;
  logic                         rdy;
  logic                         accept;
  logic signed [W1-1:0]         d1x;
  logic signed [P-1:0]          prod;

  logic [NUM_STAGE-1:0]         pv;
  logic [NUM_STAGE-1:0]         pl;
  logic signed [P-1:0]          pp [NUM_STAGE];

  logic signed [A-1:0]          acc;
  logic signed [A-1:0]          sum;
  logic                         first;
  logic signed [AW-1:0]         rsum;
  logic signed [AW-1:0]         shr;
  logic                         hi;
  logic                         lo;
  logic signed [dout_WIDTH-1:0] sat_val;

  logic                         ov;
  logic signed [dout_WIDTH-1:0] dq;
  logic                         sq;

  logic                         tail_v;
  logic                         tail_l;
  logic signed [P-1:0]          tail_p;

  assign en     = !ov | bus.out_ready;
  assign rdy    = en & !ap_rst;
  assign accept = bus.in_valid & rdy;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov;
  assign bus.dout      = dq;
  assign bus.dout_sat  = sq;

  assign d1x = DIN1_SIGNED
             ? {bus.din1[din1_WIDTH-1], bus.din1}
             : {1'b0, bus.din1};

  assign prod = $signed(bus.din0) * d1x;

  assign tail_v = pv[NUM_STAGE-1];
  assign tail_l = pl[NUM_STAGE-1];
  assign tail_p = pp[NUM_STAGE-1];

  assign sum  = (first ? '0 : acc)
              + {{GUARD_BITS{tail_p[P-1]}}, tail_p};
  assign rsum = {sum[A-1], sum} + RND;
  assign shr  = rsum >>> SHIFT;
  assign hi   = shr > MAXV;
  assign lo   = shr < MINV;

  // Clip the rounded sum into the signed output range
  always_comb begin
    sat_val = shr[dout_WIDTH-1:0];
    if (hi)
      sat_val = MAXV[dout_WIDTH-1:0];
    else if (lo)
      sat_val = MINV[dout_WIDTH-1:0];
  end

  // Product pipe: {valid, last, product} shifts on enable
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pv <= '0;
      pl <= '0;
    end else if (en) begin
      pv[0] <= accept;
      pl[0] <= accept & bus.in_last;
      pp[0] <= prod;
      for (int i = 1; i < NUM_STAGE; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  // Accumulate run, register rounded result on last tap
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc   <= '0;
      first <= 1'b1;
      ov    <= 1'b0;
      dq    <= '0;
      sq    <= 1'b0;
    end else if (en) begin
      if (tail_v) begin
        acc   <= sum;
        first <= tail_l;
      end
      ov <= tail_v & tail_l;
      if (tail_v & tail_l) begin
        dq <= sat_val;
        sq <= hi | lo;
      end
    end
  end

endmodule
